// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial-line bundle for uart_tx.
// The master drives tx_data/tx_start; the slave (transmitter) drives the rest.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_start;
  logic                 tx_ready;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_start,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_ready, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, shifted out as
// start, data LSB first, optional parity, then one or two stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     baud_reg;
  logic [BIT_W-1:0]     bit_reg;
  logic                 stop_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_reg;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;

  logic accept, tick, last_bit, last_stop;

  assign accept    = bus.tx_start && (state_reg == IDLE);
  assign tick      = (baud_reg == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_reg == BIT_W'(DATA_BITS - 1));
  assign last_stop = (stop_reg == (STOP_BITS == 2));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && last_bit) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx_next is the level for the bit that begins at the coming edge, so the
  // registered line only ever changes on bit boundaries.
  always_comb begin
    tx_next   = 1'b1;
    done_next = 1'b0;
    case (state_reg)
      IDLE:   if (accept) tx_next = 1'b0;
      START:  tx_next = tick ? shift_reg[0] : 1'b0;
      DATA: begin
        if (!tick)                  tx_next = shift_reg[0];
        else if (!last_bit)         tx_next = shift_reg[1];
        else if (PARITY_EN != 0)    tx_next = parity_reg;
      end
      PARITY: tx_next = tick ? 1'b1 : parity_reg;
      STOP:   done_next = tick && last_stop;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_reg   <= '0;
      bit_reg    <= '0;
      stop_reg   <= 1'b0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      tx_reg   <= tx_next;
      done_reg <= done_next;
      if (state_reg == IDLE) begin
        baud_reg <= '0;
        bit_reg  <= '0;
        stop_reg <= 1'b0;
        if (accept) begin
          shift_reg  <= bus.tx_data;
          parity_reg <= (^bus.tx_data) ^ (PARITY_ODD != 0);
        end
      end else begin
        baud_reg <= tick ? '0 : baud_reg + 1'b1;
        if (tick && state_reg == DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_reg   <= last_bit ? '0 : bit_reg + 1'b1;
        end
        if (tick && state_reg == STOP) stop_reg <= !stop_reg;
      end
    end
  end

  assign bus.tx_ready = (state_reg == IDLE) && !rst;
  assign bus.tx_busy  = (state_reg != IDLE);
  assign bus.tx       = tx_reg;
  assign bus.tx_done  = done_reg;
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts a parallel byte through a valid/ready handshake and shifts it out on `tx` as one asynchronous frame: start bit, data LSB first, optional parity, then stop bit(s). It is the transmit-side counterpart of `uart_rx` and uses the same frame format and line polarity (idle high). With default parameters (one clock per bit, 8N1), a `uart_tx` output wired straight to `uart_rx` input forms a loopback pair.

## Interface
- `CLKS_PER_BIT`, 1: clock cycles each bit is held on `tx`; must be ≥1.
- `DATA_BITS`, 8: payload width, 5..8.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: with `PARITY_EN`=1, 0 selects even parity and 1 selects odd parity.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  in  1  sole clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  DATA_BITS  byte to send; sampled only on acceptance.
- `tx_start`  in  1  request to send (valid).
- `tx_ready`  out  1  high when a request will be accepted this cycle.
- `tx`  out  1  serial line, registered output; idle = 1.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance happens on a rising edge where `tx_start` && `tx_ready` && !`rst`. At that edge:
  - `tx_data` is latched into the shift register;
  - parity is computed from the latched value: even parity = XOR of the data bits, odd parity = its inverse;
  - the state moves to START.
- `tx_ready` = (state == IDLE) && !`rst`. `tx_busy` = !(state == IDLE).
- A baud counter counts 0..CLKS_PER_BIT-1. Each bit state holds for exactly CLKS_PER_BIT cycles. Counter width is max(1, $clog2(CLKS_PER_BIT)).
- START drives `tx`=0, then goes to DATA.
- DATA drives `tx` = shift[0] and shifts right after each bit. After DATA_BITS bits it goes to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY drives `tx` = the parity bit, then goes to STOP.
- STOP drives `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles, then goes to IDLE. On that same edge `tx_done` is set for exactly one cycle.
- `tx_start` while busy is ignored, not queued.
- Changes on `tx_data` after acceptance have no effect on the frame in flight.
- Back-to-back frames: `tx_ready` is high in the cycle `tx_done` is high. If `tx_start` is held then, the next start bit begins on the following edge. The frame has no idle gap beyond its stop bit(s).
- Reset takes effect on the next edge, including mid-frame:
  - `tx`=1, state=IDLE, counters cleared;
  - `tx_done`=0, `tx_busy`=0, `tx_ready`=1 once `rst` is low;
  - the aborted frame produces no `tx_done`.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=0 while `rst`=1 and 1 after `rst` deasserts.
- Accept at edge E0. With the defaults (CLKS_PER_BIT=1, 8N1), `tx` is:
  - start bit during E0–E1;
  - data bit i during E(1+i)–E(2+i);
  - stop bit during E9–E10.
- At E10 the state is IDLE and `tx_done`=1 for the cycle E10–E11.
- General frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles from the accept edge to the `tx_done` edge.
- `tx` is glitch-free: it comes from a register and changes only on bit boundaries.

## Test plan
- Defaults, send 0xA5:
  - `tx` per cycle after accept = 0,1,0,1,0,0,1,0,1,1;
  - `tx_done` pulses once at cycle 10;
  - `uart_rx` in loopback reports `rx_data`=0xA5 with `rx_done`.
- Back-to-back 0x00 then 0xFF with `tx_start` held: second start bit directly follows the first stop bit; total of 20 cycles; two `tx_done` pulses, 10 cycles apart.
- CLKS_PER_BIT=4, send 0x3C: each bit held exactly 4 cycles; `tx_done` at cycle 40; `tx_ready` low throughout the frame.
- PARITY_EN=1, send 0x07:
  - PARITY_ODD=0 gives parity bit 1;
  - PARITY_ODD=1 gives parity bit 0;
  - frame is 11 cycles at CLKS_PER_BIT=1.
- Assert `rst` for one cycle during data bit 3 of 0x5A: `tx`=1 on the next edge; no `tx_done`; `tx_ready`=1 once `rst` is low; a following send of 0x81 transmits correctly.
- Pulse `tx_start` with 0x11 during a 0xEE frame, and change `tx_data` mid-frame: only 0xEE is transmitted, unaltered; no second frame starts.
